// File: rtl/uart_pkg.sv
// Shared UART definitions: default byte width, FIFO sizing defaults and a
// saturating increment used by the stats counters.
package uart_pkg;

   localparam int DEF_DATA_BITS  = 8;
   localparam int DEF_DEPTH_LOG2 = 4;
   localparam int DEF_DEPTH      = 1 << DEF_DEPTH_LOG2;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Valid/ready byte stream from the receive FIFO to the host-side consumer.
interface uart_rx_fifo_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] m_data;
   logic                 m_valid;
   logic                 m_ready;

   modport master (
      output m_data,
      output m_valid,
      input  m_ready
   );

   modport slave (
      input  m_data,
      input  m_valid,
      output m_ready
   );
endinterface

// File: rtl/uart_edge_detect.sv
// Single-cycle rising-edge strobe. RST_VAL = 1 suppresses a strobe when the
// input is already high as reset releases.
module uart_edge_detect #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic d_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_q <= RST_VAL;
      end else begin
         d_q <= d;
      end
   end

   assign rise = d & ~d_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer behind Uart8Receiver: first-word-fall-through FIFO with
// framing-error discard and sticky overflow. Optional UART_RX_FIFO_STATS_EN
// adds saturating frame-error and drop counters.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_BITS   = DEF_DATA_BITS,
   parameter int DEPTH_LOG2  = DEF_DEPTH_LOG2,
   parameter int ALMOST_FULL = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_BITS-1:0]  rx_data,
   input  logic                  rx_done,
   input  logic                  rx_err,
   uart_rx_fifo_if.master        m_if,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  almost_full,
   output logic                  overflow,
   input  logic                  clr_overflow
`ifdef UART_RX_FIFO_STATS_EN
   ,
   output logic [15:0]           frame_err_cnt,
   output logic [15:0]           drop_cnt
`endif
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] AF_CNT   = CW'(ALMOST_FULL);

   logic [DATA_BITS-1:0]  mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;

   logic cap;
   logic good;
   logic full;
   logic pop;
   logic push;
   logic drop;

   uart_edge_detect #(
      .RST_VAL (1'b1)
   ) u_done_edge (
      .clk  (clk),
      .rst  (rst),
      .d    (rx_done),
      .rise (cap)
   );

   assign full = (count == FULL_CNT);
   assign pop  = m_if.m_valid & m_if.m_ready;
   assign good = cap & ~rx_err;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push = good & (~full | pop);
   assign drop = good & full & ~pop;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= rx_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (clr_overflow) begin
         overflow <= 1'b0;
      end
   end

`ifdef UART_RX_FIFO_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_err_cnt <= '0;
         drop_cnt      <= '0;
      end else begin
         if (cap && rx_err) begin
            frame_err_cnt <= sat_inc16(frame_err_cnt);
         end else if (clr_overflow) begin
            frame_err_cnt <= '0;
         end
         if (drop) begin
            drop_cnt <= sat_inc16(drop_cnt);
         end else if (clr_overflow) begin
            drop_cnt <= '0;
         end
      end
   end
`endif

   assign m_if.m_data  = mem[rd_ptr];
   assign m_if.m_valid = (count != '0);
   assign almost_full  = (count >= AF_CNT);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: table-driven fill sequence plus
// hand-written corner cases, with a queue scoreboard for byte order.
module tb_uart_rx_fifo;

   localparam int DB    = 8;
   localparam int DL2   = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [DB-1:0] rx_data;
   logic          rx_done;
   logic          rx_err;
   logic [DL2:0]  count;
   logic          almost_full;
   logic          overflow;
   logic          clr_overflow;
`ifdef UART_RX_FIFO_STATS_EN
   logic [15:0]   frame_err_cnt;
   logic [15:0]   drop_cnt;
`endif

   uart_rx_fifo_if #(.DATA_BITS(DB)) m_if ();

   uart_rx_fifo #(
      .DATA_BITS   (DB),
      .DEPTH_LOG2  (DL2),
      .ALMOST_FULL (12)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_data      (rx_data),
      .rx_done      (rx_done),
      .rx_err       (rx_err),
      .m_if         (m_if),
      .count        (count),
      .almost_full  (almost_full),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
`ifdef UART_RX_FIFO_STATS_EN
      ,
      .frame_err_cnt (frame_err_cnt),
      .drop_cnt      (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       err;
      int         exp_count;
      logic       exp_af;
      logic       exp_ovf;
   } vec_t;

   vec_t           vecs[17];
   logic [7:0]     sb[$];
   int             n_checks = 0;
   int             n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Model: good byte enters the scoreboard only if there is room.
   task automatic send(input logic [7:0] d, input logic e);
      rx_data = d;
      rx_err  = e;
      rx_done = 1'b1;
      step();
      if (!e && sb.size() < DEPTH) sb.push_back(d);
      rx_done = 1'b0;
      rx_err  = 1'b0;
      step();
   endtask

   task automatic drain(output logic [7:0] last);
      int guard;
      logic [7:0] exp;
      guard = 0;
      last  = 8'h00;
      while (m_if.m_valid && guard < 40) begin
         if (sb.size() == 0) begin
            chk("drain_extra_byte", 32'(m_if.m_data), 32'hFFFF_FFFF);
            exp = 8'h00;
         end else begin
            exp = sb.pop_front();
            chk("drain_data", 32'(m_if.m_data), 32'(exp));
         end
         last = m_if.m_data;
         m_if.m_ready = 1'b1;
         step();
         m_if.m_ready = 1'b0;
         guard++;
      end
      chk("drain_bound", 32'(guard < 40), 32'd1);
      chk("drain_count", 32'(count), 32'd0);
      chk("drain_sb_empty", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      logic [7:0] last;

      for (int i = 0; i < 17; i++) begin
         vecs[i].data      = 8'(i);
         vecs[i].err       = 1'b0;
         vecs[i].exp_count = (i + 1 > DEPTH) ? DEPTH : i + 1;
         vecs[i].exp_af    = ((i + 1) >= 12);
         vecs[i].exp_ovf   = (i == 16);
      end

      rst = 1'b1;
      rx_data = 8'h00;
      rx_done = 1'b0;
      rx_err = 1'b0;
      m_if.m_ready = 1'b0;
      clr_overflow = 1'b0;
      step();
      step();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_valid", 32'(m_if.m_valid), 32'd0);
      chk("rst_af", 32'(almost_full), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
`ifdef UART_RX_FIFO_STATS_EN
      chk("rst_fe_cnt", 32'(frame_err_cnt), 32'd0);
      chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
      rst = 1'b0;
      step();

      // Empty FIFO ignores m_ready
      m_if.m_ready = 1'b1;
      step(); step(); step();
      m_if.m_ready = 1'b0;
      chk("empty_ready_count", 32'(count), 32'd0);

      // 1: two bytes, single pop
      send(8'h55, 1'b0);
      send(8'h96, 1'b0);
      chk("t1_count", 32'(count), 32'd2);
      chk("t1_valid", 32'(m_if.m_valid), 32'd1);
      chk("t1_data", 32'(m_if.m_data), 32'h55);
      m_if.m_ready = 1'b1;
      step();
      m_if.m_ready = 1'b0;
      void'(sb.pop_front());
      chk("t1_data_after_pop", 32'(m_if.m_data), 32'h96);
      chk("t1_count_after_pop", 32'(count), 32'd1);
      drain(last);

      // 2: long done pulse yields one capture
      rx_data = 8'hA3;
      rx_done = 1'b1;
      for (int i = 0; i < 40; i++) step();
      rx_done = 1'b0;
      step();
      sb.push_back(8'hA3);
      chk("t2_count", 32'(count), 32'd1);
      drain(last);

      // 3: framing error discarded
      send(8'hFF, 1'b1);
      chk("t3_count", 32'(count), 32'd0);
      chk("t3_ovf", 32'(overflow), 32'd0);
`ifdef UART_RX_FIFO_STATS_EN
      chk("t3_fe_cnt", 32'(frame_err_cnt), 32'd1);
`endif

      // 4: table-driven fill to overflow
      for (int i = 0; i < 17; i++) begin
         send(vecs[i].data, vecs[i].err);
         chk("t4_count", 32'(count), 32'(vecs[i].exp_count));
         chk("t4_af", 32'(almost_full), 32'(vecs[i].exp_af));
         chk("t4_ovf", 32'(overflow), 32'(vecs[i].exp_ovf));
      end
`ifdef UART_RX_FIFO_STATS_EN
      chk("t4_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
      drain(last);
      chk("t4_last", 32'(last), 32'h0F);
      chk("t4_ovf_before_clr", 32'(overflow), 32'd1);
      clr_overflow = 1'b1;
      step();
      clr_overflow = 1'b0;
      chk("t4_ovf_cleared", 32'(overflow), 32'd0);
`ifdef UART_RX_FIFO_STATS_EN
      chk("t4_fe_cleared", 32'(frame_err_cnt), 32'd0);
      chk("t4_drop_cleared", 32'(drop_cnt), 32'd0);
`endif

      // 5: full FIFO with simultaneous pop and capture
      for (int i = 0; i < DEPTH; i++) send(8'h20 + 8'(i), 1'b0);
      chk("t5_full", 32'(count), 32'd16);
      rx_data = 8'h77;
      rx_done = 1'b1;
      m_if.m_ready = 1'b1;
      chk("t5_head", 32'(m_if.m_data), 32'h20);
      step();
      m_if.m_ready = 1'b0;
      rx_done = 1'b0;
      void'(sb.pop_front());
      sb.push_back(8'h77);
      chk("t5_count", 32'(count), 32'd16);
      chk("t5_ovf", 32'(overflow), 32'd0);
      step();
      drain(last);
      chk("t5_last", 32'(last), 32'h77);

      // 6: async reset with rx_done held high
      for (int i = 0; i < 4; i++) send(8'h40 + 8'(i), 1'b0);
      rx_data = 8'h44;
      rx_done = 1'b1;
      step();
      chk("t6_count5", 32'(count), 32'd5);
      #2 rst = 1'b1;
      #1;
      chk("t6_async_count", 32'(count), 32'd0);
      chk("t6_async_valid", 32'(m_if.m_valid), 32'd0);
      chk("t6_async_af", 32'(almost_full), 32'd0);
      chk("t6_async_ovf", 32'(overflow), 32'd0);
      sb.delete();
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("t6_no_capture", 32'(count), 32'd0);
      rx_done = 1'b0;
      step();
      rx_data = 8'hC5;
      send(8'hC5, 1'b0);
      chk("t6_recapture", 32'(count), 32'd1);
      chk("t6_data", 32'(m_if.m_data), 32'hC5);
      drain(last);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer that sits directly downstream of Uart8Receiver. It captures each completed byte (out/done/err) into a first-word-fall-through FIFO. Bytes are presented to the consumer on a valid/ready interface. The block also discards framing-error bytes and flags overflow, which decouples the bit-rate receiver from the slower host logic.

Parameters:
DATA_BITS, 8, width of the received byte; must match the receiver's DATA_BITS.
DEPTH_LOG2, 4, log2 of FIFO depth (DEPTH = 16).
ALMOST_FULL, 12, count at or above which almost_full asserts; legal range 1..DEPTH.

Ports:
clk  in  1  system clock; same clock as the receiver.
rst  in  1  asynchronous, active-high reset.
rx_data  in  DATA_BITS  receiver out bus; valid when rx_done rises.
rx_done  in  1  receiver done; may stay high for several cycles.
rx_err  in  1  receiver framing error; sampled together with rx_done.
m_data  out  DATA_BITS  head-of-FIFO byte.
m_valid  out  1  FIFO not empty.
m_ready  in  1  consumer accepts m_data when m_valid && m_ready.
count  out  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
almost_full  out  1  count >= ALMOST_FULL.
overflow  out  1  sticky: a good byte was dropped because the FIFO was full.
clr_overflow  in  1  single-cycle clear of overflow.

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - m_valid = 0, almost_full = 0, overflow = 0.
  - done_q = 1. This blocks a spurious capture if rx_done is already high when reset releases.
  - m_data is don't-care while m_valid = 0.
- Capture event: cap = rx_done && !done_q; done_q <= rx_done every cycle. A done held high for N cycles yields exactly one capture.
- Bad byte: cap && rx_err -> byte discarded; no pointer change; overflow unaffected.
- Push: push = cap && !rx_err && (count < DEPTH || pop).
  - Data is written at mem[wr_ptr]; wr_ptr increments and wraps modulo DEPTH.
- Pop: pop = m_valid && m_ready; rd_ptr increments and wraps modulo DEPTH.
- Count: count <= count + push - pop.
- Full with simultaneous pop: the push is accepted and count stays at DEPTH.
- Overflow set: cap && !rx_err && count == DEPTH && !pop -> byte dropped, overflow <= 1.
  - If the set condition and clr_overflow coincide, set wins.
- Output timing: m_data = mem[rd_ptr] combinationally (FWFT).
  - m_valid and almost_full are derived combinationally from the registered count.
  - Latency: capture cycle N -> m_valid/m_data visible from cycle N+1.
- Empty: pop is impossible because m_valid = 0, so m_ready is ignored and count never underflows.
- rx_data is sampled only on cap; there is no requirement on it at other times.
- Reset mid-operation: all contents are lost and pointers return to 0. The first capture after release needs a fresh rising edge of rx_done.

Optional Feature:
UART_RX_FIFO_STATS_EN
- Defined: adds outputs frame_err_cnt[15:0] and drop_cnt[15:0], both reset to 0.
  - frame_err_cnt increments on each cap && rx_err.
  - drop_cnt increments on each overflow-drop event.
  - Both saturate at 16'hFFFF.
  - clr_overflow also clears both counters (increment wins on a coincident event).
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package uart_pkg holds:
  - DATA_BITS default (8);
  - localparam DEPTH = 1 << DEPTH_LOG2;
  - a saturating-increment function shared with future UART stats blocks.
- One natural sub-module: uart_edge_detect (rising-edge detector with a reset value parameter), reused for the transmitter's start strobe.
- The storage array and pointers stay in uart_rx_fifo.

Test Plan:
1. Receive 0x55 then 0x96 with no error, m_ready = 0 -> count = 2, m_valid = 1, m_data = 0x55. Pulse m_ready for one cycle -> m_data = 0x96, count = 1.
2. Hold rx_done high 40 cycles with rx_data = 0xA3 -> exactly one entry, count = 1.
3. Capture with rx_err = 1 and rx_data = 0xFF -> count unchanged, overflow = 0, frame_err_cnt = 1 (STATS_EN).
4. Push bytes 0x00..0x0F with m_ready = 0:
   - almost_full rises when count reaches 12;
   - a 17th byte 0x10 sets overflow, count = 16, drop_cnt = 1;
   - draining yields 0x00..0x0F in order;
   - clr_overflow then clears overflow.
5. FIFO full and m_ready = 1 on the same cycle as capture of 0x77 -> the 0x77 push is accepted, count stays 16, overflow stays 0, 0x77 emerges last.
6. Assert rst while count = 5 and rx_done is high -> outputs return to reset values immediately (async). After release, no capture occurs until rx_done falls and rises again.
